// File: rtl/branch_resolution_unit.sv
// Branch resolution: carries F-stage predictions to EX, flags mispredicts,
// drives the predictor update and keeps saturating perf counters.
module branch_resolution_unit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 stall_d_i,
  input  logic                 flush_d_i,
  input  logic                 stall_e_i,
  input  logic                 flush_e_i,
  input  logic                 branch_f_i,
  input  logic                 pc_src_pred_f_i,
  input  logic [WIDTH-1:0]     pc_plus4_f_i,
  input  logic                 branch_e_i,
  input  logic                 pc_src_res_ex_i,
  input  logic [WIDTH-1:0]     pc_target_ex_i,
  output logic                 mispredict_o,
  output logic [WIDTH-1:0]     redirect_pc_o,
  output logic                 pred_update_en_o,
  output logic                 pc_src_res_o,
  output logic [CNT_WIDTH-1:0] branch_cnt_o,
  output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

  typedef struct packed {
    logic             pred;
    logic [WIDTH-1:0] pc_plus4;
  } pipe_t;

  pipe_t                r_fd;
  pipe_t                r_de;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_mispred_cnt;

  logic                 w_mispredict;
  logic                 w_update_en;
  pipe_t                w_fd_next;

  assign w_fd_next.pred     = pc_src_pred_f_i & branch_f_i;
  assign w_fd_next.pc_plus4 = pc_plus4_f_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fd <= '0;
    end else if (flush_d_i) begin
      r_fd <= '0;
    end else if (!stall_d_i) begin
      r_fd <= w_fd_next;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_de <= '0;
    end else if (flush_e_i) begin
      r_de <= '0;
    end else if (!stall_e_i) begin
      r_de <= r_fd;
    end
  end

  // Gate with reset so a branch sitting in EX during reset emits nothing.
  assign w_mispredict = reset_n_i & branch_e_i &
                        (r_de.pred != pc_src_res_ex_i);
  assign w_update_en  = reset_n_i & branch_e_i & ~stall_e_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_update_en) begin
      if (r_branch_cnt != '1) begin
        r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (w_mispredict && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  assign mispredict_o     = w_mispredict;
  assign redirect_pc_o    = pc_src_res_ex_i ? pc_target_ex_i
                                            : r_de.pc_plus4;
  assign pred_update_en_o = w_update_en;
  assign pc_src_res_o     = pc_src_res_ex_i;
  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench for branch_resolution_unit: expected EX responses are
// queued at issue and checked by a monitor on each predictor update.
module tb_branch_resolution_unit;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          stall_d;
  logic          flush_d;
  logic          stall_e;
  logic          flush_e;
  logic          br_f;
  logic          pred_f;
  logic [W-1:0]  pc4_f;
  logic          br_e;
  logic          res_e;
  logic [W-1:0]  tgt_e;
  logic          mp;
  logic [W-1:0]  rpc;
  logic          upd;
  logic          res_o;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] mcnt;

  typedef struct {
    logic         mp;
    logic [W-1:0] rpc;
    logic         res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_resolution_unit #(
    .WIDTH    (W),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .stall_d_i       (stall_d),
    .flush_d_i       (flush_d),
    .stall_e_i       (stall_e),
    .flush_e_i       (flush_e),
    .branch_f_i      (br_f),
    .pc_src_pred_f_i (pred_f),
    .pc_plus4_f_i    (pc4_f),
    .branch_e_i      (br_e),
    .pc_src_res_ex_i (res_e),
    .pc_target_ex_i  (tgt_e),
    .mispredict_o    (mp),
    .redirect_pc_o   (rpc),
    .pred_update_en_o(upd),
    .pc_src_res_o    (res_o),
    .branch_cnt_o    (bcnt),
    .mispredict_cnt_o(mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every update pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (upd === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_update: got 1 expected 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mispredict", 64'(mp), 64'(e.mp));
        chk("res_fwd", 64'(res_o), 64'(e.res));
        if (e.mp) chk("redirect", 64'(rpc), 64'(e.rpc));
      end
    end
  end

  task automatic push(input logic m, input logic [W-1:0] pc,
                      input logic r);
    exp_t e;
    e.mp  = m;
    e.rpc = pc;
    e.res = r;
    sb.push_back(e);
  endtask

  task automatic clear_ex();
    br_e    = 1'b0;
    res_e   = 1'b0;
    tgt_e   = '0;
    flush_e = 1'b0;
  endtask

  task automatic issue(input logic br, input logic pr,
                       input logic [W-1:0] pc4, input logic res,
                       input logic [W-1:0] tgt, input logic m,
                       input logic [W-1:0] rdir, input logic fl);
    br_f   = br;
    pred_f = pr;
    pc4_f  = pc4;
    @(posedge clk); #1;
    br_f   = 1'b0;
    pred_f = 1'b0;
    pc4_f  = '0;
    @(posedge clk); #1;
    br_e    = 1'b1;
    res_e   = res;
    tgt_e   = tgt;
    flush_e = fl;
    push(m, rdir, res);
    @(posedge clk); #1;
    clear_ex();
  endtask

  initial begin
    rst_n   = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    br_f    = 1'b0;
    pred_f  = 1'b0;
    pc4_f   = '0;
    clear_ex();
    #2;
    chk("rst_bcnt", 64'(bcnt), 64'd0);
    chk("rst_mcnt", 64'(mcnt), 64'd0);
    chk("rst_upd", 64'(upd), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: predicted taken, resolved taken
    issue(1, 1, 32'h10, 1, 32'h100, 0, 32'h100, 0);
    chk("t1_bcnt", 64'(bcnt), 64'd1);
    chk("t1_mcnt", 64'(mcnt), 64'd0);

    // non-branch in F with pred=1 must carry pred=0
    issue(0, 1, 32'h60, 0, 32'h600, 0, 32'h60, 0);
    chk("nb_bcnt", 64'(bcnt), 64'd2);

    // 2: predicted not-taken, resolved taken
    issue(1, 0, 32'h44, 1, 32'h80, 1, 32'h80, 0);
    chk("t2_bcnt", 64'(bcnt), 64'd3);
    chk("t2_mcnt", 64'(mcnt), 64'd1);

    // 3: predicted taken, resolved not-taken, flush_e in same cycle
    issue(1, 1, 32'h24, 0, 32'h200, 1, 32'h24, 1);
    chk("t3_bcnt", 64'(bcnt), 64'd4);
    chk("t3_mcnt", 64'(mcnt), 64'd2);

    // 4: branch stalled three cycles in EX
    br_f  = 1'b1;
    pc4_f = 32'h30;
    @(posedge clk); #1;
    br_f  = 1'b0;
    pc4_f = '0;
    @(posedge clk); #1;
    br_e    = 1'b1;
    stall_e = 1'b1;
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_upd", 64'(upd), 64'd0);
      @(posedge clk); #1;
    end
    stall_e = 1'b0;
    stall_d = 1'b0;
    push(0, 32'h30, 0);
    @(posedge clk); #1;
    clear_ex();
    chk("t4_bcnt", 64'(bcnt), 64'd5);
    chk("t4_mcnt", 64'(mcnt), 64'd2);

    // 5: predicted-taken branch squashed by flush_e while loading DE
    br_f   = 1'b1;
    pred_f = 1'b1;
    pc4_f  = 32'h50;
    @(posedge clk); #1;
    br_f    = 1'b0;
    pred_f  = 1'b0;
    pc4_f   = '0;
    flush_e = 1'b1;
    @(posedge clk); #1;
    flush_e = 1'b0;
    br_e    = 1'b1;
    tgt_e   = 32'h500;
    push(0, 32'h0, 0);
    @(posedge clk); #1;
    clear_ex();
    chk("t5_bcnt", 64'(bcnt), 64'd6);
    chk("t5_mcnt", 64'(mcnt), 64'd2);

    // 6: drive both counters into saturation
    for (int i = 0; i < 13; i++) begin
      issue(1, 0, 32'h70, 1, 32'h300 + 32'(i * 4), 1,
            32'h300 + 32'(i * 4), 0);
    end
    chk("sat_bcnt", 64'(bcnt), 64'd15);
    chk("sat_mcnt", 64'(mcnt), 64'd15);
    issue(1, 0, 32'h74, 1, 32'h3f0, 1, 32'h3f0, 0);
    chk("sat_hold_bcnt", 64'(bcnt), 64'd15);
    chk("sat_hold_mcnt", 64'(mcnt), 64'd15);

    // reset mid-cycle with a would-be mispredict in EX
    br_f  = 1'b1;
    pc4_f = 32'h88;
    @(posedge clk); #1;
    br_f  = 1'b0;
    pc4_f = '0;
    @(posedge clk); #1;
    br_e  = 1'b1;
    res_e = 1'b1;
    tgt_e = 32'h400;
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_bcnt", 64'(bcnt), 64'd0);
    chk("r_mcnt", 64'(mcnt), 64'd0);
    chk("r_mp", 64'(mp), 64'd0);
    chk("r_upd", 64'(upd), 64'd0);
    chk("r_rpc_taken", 64'(rpc), 64'h400);
    res_e = 1'b0;
    #1;
    chk("r_rpc_fall", 64'(rpc), 64'd0);
    @(posedge clk); #1;
    clear_ex();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("end_bcnt", 64'(bcnt), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
